// File: rtl/mips_prog_loader.sv
// Boot loader: parses a framed byte stream into big-endian words, writes them to
// core memory, then releases the core at the load address or parks it on error.
module mips_prog_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic [ADDR_W-1:0] pc_init,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {HDR, DATA, CSUM, RUN, ERR} state_t;

    state_t            state;
    logic [1:0]        hdr_cnt;
    logic [1:0]        byte_cnt;
    logic [23:0]       hdr_buf;
    logic [15:0]       remain;
    logic [ADDR_W-1:0] addr;
    logic [23:0]       word;
    logic [7:0]        sum;

    logic              accept;
    logic [15:0]       hdr_addr;
    logic [15:0]       hdr_len;
    logic [16:0]       hdr_end;
    logic              hdr_bad;
    logic [7:0]        sum_nxt;
    logic [31:0]       word_nxt;

    // Header fields are complete only while the 4th header byte is on in_data.
    assign accept   = in_valid & in_ready;
    assign hdr_addr = hdr_buf[23:8];
    assign hdr_len  = {hdr_buf[7:0], in_data};
    assign hdr_end  = {1'b0, hdr_addr} + {1'b0, hdr_len};
    assign hdr_bad  = (hdr_addr[15:ADDR_W] != '0) || (hdr_end > DEPTH);
    assign sum_nxt  = sum + in_data;
    assign word_nxt = {word, in_data};

    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= HDR;
            hdr_cnt   <= 2'd0;
            byte_cnt  <= 2'd0;
            hdr_buf   <= 24'd0;
            remain    <= 16'd0;
            addr      <= '0;
            word      <= 24'd0;
            sum       <= 8'd0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            cpu_run   <= 1'b0;
            pc_init   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    HDR: begin
                        sum     <= sum_nxt;
                        busy    <= 1'b1;
                        hdr_cnt <= hdr_cnt + 2'd1;
                        hdr_buf <= {hdr_buf[15:0], in_data};
                        if (hdr_cnt == 2'd3) begin
                            pc_init <= hdr_addr[ADDR_W-1:0];
                            if (hdr_bad) begin
                                state    <= ERR;
                                err      <= 1'b1;
                                busy     <= 1'b0;
                                in_ready <= 1'b0;
                            end else begin
                                addr   <= hdr_addr[ADDR_W-1:0];
                                remain <= hdr_len;
                                state  <= (hdr_len == 16'd0) ? CSUM : DATA;
                            end
                        end
                    end
                    DATA: begin
                        sum      <= sum_nxt;
                        word     <= word_nxt[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= word_nxt;
                            addr      <= addr + ADDR_W'(1);
                            remain    <= remain - 16'd1;
                            if (remain == 16'd1) state <= CSUM;
                        end
                    end
                    CSUM: begin
                        sum      <= sum_nxt;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        if (sum_nxt == 8'd0) begin
                            state   <= RUN;
                            cpu_run <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: frame loads, checksum and header errors,
// stream gaps and mid-frame reset, with a write monitor on the memory port.
module tb_mips_prog_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic [ADDR_W-1:0] pc_init;
    logic              busy;
    logic              done;
    logic              err;

    mips_prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_run   (cpu_run),
        .pc_init   (pc_init),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk1 = ~clk1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_wr = 0;
    int base;
    logic [ADDR_W-1:0] wr_addr [64];
    logic [31:0]       wr_data [64];
    int                wr_cyc  [64];
    logic [31:0]       words   [8];
    logic [7:0]        bq      [$];

    always @(posedge clk1) cyc <= cyc + 1;

    // Every cycle with mem_we high is logged, so a stuck strobe shows up as extra writes.
    always @(negedge clk1) begin
        if (mem_we === 1'b1) begin
            if (n_wr < 64) begin
                wr_addr[n_wr] = mem_addr;
                wr_data[n_wr] = mem_wdata;
                wr_cyc[n_wr]  = cyc;
            end
            n_wr = n_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        check({tag, "_cpu_run"},   32'(cpu_run),   32'd0);
        check({tag, "_pc_init"},   32'(pc_init),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk1);
        rst = 1'b1;
        @(posedge clk1);
        #1;
        rst = 1'b0;
        chk_reset(tag);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk1);
        #1;
        in_valid = 1'b0;
    endtask

    // Frame = header, words MSB first, then the byte that zeroes the sum (plus adj).
    task automatic build(input logic [15:0] a, input logic [15:0] c, input int nw, input int adj);
        int s;
        bq.delete();
        bq.push_back(a[15:8]);
        bq.push_back(a[7:0]);
        bq.push_back(c[15:8]);
        bq.push_back(c[7:0]);
        for (int i = 0; i < nw; i++) begin
            bq.push_back(words[i][31:24]);
            bq.push_back(words[i][23:16]);
            bq.push_back(words[i][15:8]);
            bq.push_back(words[i][7:0]);
        end
        s = 0;
        foreach (bq[i]) s += int'(bq[i]);
        bq.push_back(8'(256 - (s % 256) + adj));
    endtask

    task automatic send_all(input bit gaps);
        foreach (bq[i]) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(posedge clk1);
            send_byte(bq[i]);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        do_reset("rst0");

        // Back-to-back 3-word program at address 0.
        words[0] = 32'h28010078;
        words[1] = 32'h0ce77800;
        words[2] = 32'h20220000;
        build(16'h0000, 16'd3, 3, 0);
        check("t1_csum_byte", 32'(bq[16]), 32'h000000af);
        base = n_wr;
        send_all(1'b0);
        check("t1_done",     32'(done),     32'd1);
        check("t1_cpu_run",  32'(cpu_run),  32'd1);
        check("t1_err",      32'(err),      32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        check("t1_busy",     32'(busy),     32'd0);
        check("t1_pc_init",  32'(pc_init),  32'd0);
        check("t1_nwr",      32'(n_wr - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_addr%0d", i), 32'(wr_addr[base + i]), 32'(i));
            check($sformatf("t1_data%0d", i), wr_data[base + i], words[i]);
        end
        check("t1_gap1", 32'(wr_cyc[base + 1] - wr_cyc[base]), 32'd4);
        check("t1_gap2", 32'(wr_cyc[base + 2] - wr_cyc[base + 1]), 32'd4);

        // Same frame with checksum off by one; later bytes must be ignored.
        do_reset("rst2");
        build(16'h0000, 16'd3, 3, 1);
        base = n_wr;
        send_all(1'b0);
        check("t2_nwr",      32'(n_wr - base), 32'd3);
        check("t2_data2",    wr_data[base + 2], 32'h20220000);
        check("t2_err",      32'(err),      32'd1);
        check("t2_cpu_run",  32'(cpu_run),  32'd0);
        check("t2_done",     32'(done),     32'd0);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h55);
        check("t2_nwr_after", 32'(n_wr - base), 32'd3);
        check("t2_err_after", 32'(err),  32'd1);
        check("t2_busy",      32'(busy), 32'd0);
        check("t2_done_after", 32'(done), 32'd0);

        // Empty frame at 0x0078.
        do_reset("rst3");
        build(16'h0078, 16'd0, 0, 0);
        base = n_wr;
        for (int i = 0; i < 4; i++) send_byte(bq[i]);
        check("t3_busy_hdr",  32'(busy),     32'd1);
        check("t3_pc_hdr",    32'(pc_init),  32'd120);
        check("t3_ready_hdr", 32'(in_ready), 32'd1);
        send_byte(bq[4]);
        check("t3_done",    32'(done),    32'd1);
        check("t3_cpu_run", 32'(cpu_run), 32'd1);
        check("t3_pc_init", 32'(pc_init), 32'd120);
        check("t3_nwr",     32'(n_wr - base), 32'd0);

        // Header range checks.
        for (int i = 0; i < 5; i++) words[i] = 32'h11110000 + 32'(i);
        do_reset("rst4a");
        build(16'd1020, 16'd5, 5, 0);
        base = n_wr;
        for (int i = 0; i < 4; i++) send_byte(bq[i]);
        check("t4a_err",   32'(err),      32'd1);
        check("t4a_ready", 32'(in_ready), 32'd0);
        check("t4a_busy",  32'(busy),     32'd0);
        repeat (6) @(posedge clk1);
        check("t4a_nwr",   32'(n_wr - base), 32'd0);
        do_reset("rst4b");
        build(16'h0400, 16'd5, 5, 0);
        base = n_wr;
        for (int i = 0; i < 4; i++) send_byte(bq[i]);
        check("t4b_err",   32'(err),      32'd1);
        check("t4b_ready", 32'(in_ready), 32'd0);
        do_reset("rst4c");
        build(16'd1019, 16'd5, 5, 0);
        base = n_wr;
        send_all(1'b0);
        check("t4c_done",  32'(done), 32'd1);
        check("t4c_err",   32'(err),  32'd0);
        check("t4c_nwr",   32'(n_wr - base), 32'd5);
        check("t4c_addr0", 32'(wr_addr[base]),     32'd1019);
        check("t4c_addr4", 32'(wr_addr[base + 4]), 32'd1023);
        check("t4c_data4", wr_data[base + 4], 32'h11110004);

        // Two words with random in_valid gaps.
        do_reset("rst5");
        words[0] = 32'hdeadbeef;
        words[1] = 32'h01234567;
        build(16'h0100, 16'd2, 2, 0);
        base = n_wr;
        send_all(1'b1);
        check("t5_nwr",   32'(n_wr - base), 32'd2);
        check("t5_addr0", 32'(wr_addr[base]),     32'h100);
        check("t5_data0", wr_data[base],           32'hdeadbeef);
        check("t5_addr1", 32'(wr_addr[base + 1]), 32'h101);
        check("t5_data1", wr_data[base + 1],       32'h01234567);
        check("t5_done",  32'(done), 32'd1);

        // Reset mid-word, then a fresh frame.
        do_reset("rst6a");
        words[0] = 32'haaaa5555;
        words[1] = 32'hcafef00d;
        build(16'h0010, 16'd2, 2, 0);
        base = n_wr;
        for (int i = 0; i < 10; i++) send_byte(bq[i]);
        check("t6_nwr_pre", 32'(n_wr - base), 32'd1);
        check("t6_busy",    32'(busy), 32'd1);
        do_reset("t6_rst");
        words[0] = 32'h13572468;
        build(16'h0020, 16'd1, 1, 0);
        base = n_wr;
        send_all(1'b0);
        check("t6_nwr",  32'(n_wr - base), 32'd1);
        check("t6_addr", 32'(wr_addr[base]), 32'h20);
        check("t6_data", wr_data[base], 32'h13572468);
        check("t6_done", 32'(done), 32'd1);
        check("t6_pc",   32'(pc_init), 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Boot-time program loader sitting directly upstream of the pipelined MIPS core. It receives a framed byte stream over a valid/ready channel, assembles big-endian 32-bit words, and writes them into the core's unified word memory. It then releases the core to run from the load address, or holds it parked on a framing or checksum error.

## Interface
- ADDR_W, 10, word-address width; memory depth is 2^ADDR_W words.
- clk1  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  byte offered on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; transfer occurs on an edge where in_valid & in_ready.
- mem_we  out  1  one-cycle word write strobe to core memory.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  word to write.
- cpu_run  out  1  0 keeps the core halted (HALTED=1, branch state cleared); 1 releases it.
- pc_init  out  ADDR_W  PC value the core loads when cpu_run rises.
- busy  out  1  frame in progress (header or data or checksum byte received, not yet finished).
- done  out  1  frame loaded and checksum good; sticky until rst.
- err  out  1  frame rejected; sticky until rst.

## Operation
- Frame format: ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then 4*CNT data bytes (MSB first per word), then one CSUM byte.
- Checksum rule: the 8-bit modulo-256 sum of every frame byte, including CSUM, must equal 0x00.
- FSM states: HDR, DATA, CSUM, RUN, ERR.
- HDR: 2-bit byte counter collects 4 bytes into a 16-bit start address and a 16-bit count.
- On the 4th header byte, the loader moves to ERR if either condition holds:
  - start address bits above ADDR_W are nonzero.
  - start + CNT > 2^ADDR_W, evaluated at 17 bits.
- Otherwise, on the 4th header byte, it moves to DATA if CNT > 0, or to CSUM if CNT = 0.
- DATA: bytes are shifted into a 32-bit word register.
  - On every 4th byte, write the word at the current address, increment the address, and decrement the remaining count.
  - After the last word, move to CSUM.
- CSUM: on acceptance, move to RUN if the running sum is 0, otherwise to ERR.
- RUN: cpu_run=1 and done=1. Terminal until rst.
- ERR: err=1 and cpu_run=0. Terminal until rst. Memory words already written are not restored.
- pc_init equals the latched start address from the 4th header byte onward.
- in_ready is 1 in HDR, DATA and CSUM, and 0 in RUN and ERR.
- in_valid gaps of any length are legal; state holds between accepted bytes.
- busy is 1 from the first accepted byte until the frame reaches RUN or ERR.
- Bytes presented while in_ready=0 are ignored; they are neither counted nor summed.

## Timing
- Reset values (the cycle after rst is sampled high):
  - State is HDR and all counters and the running sum are 0.
  - in_ready=1; mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_run=0, pc_init=0, busy=0, done=0, err=0.
- rst has priority over every other input. Asserting it mid-frame aborts the frame with no further writes; the next accepted byte is ADDR_HI.
- All outputs are registered.
- Write latency: when the 4th byte of a word is accepted at edge k, mem_we/mem_addr/mem_wdata are valid for exactly the cycle after edge k.
  - With back-to-back input, consecutive writes are 4 cycles apart.
- Completion latency: when the CSUM byte is accepted at edge k, done/cpu_run or err is 1 in the cycle after edge k. in_ready is 0 in that same cycle.
- Header-error latency: when the 4th header byte is accepted at edge k, err=1 and in_ready=0 in the cycle after edge k. No mem_we is issued.
- Throughput: 1 byte per cycle sustained.

## Test plan
- Load a frame with addr 0, CNT 3, words 28010078, 0ce77800, 20220000 and a correct CSUM, back-to-back.
  - Expect mem_we pulses at addr 0/1/2 with the exact words, 4 cycles apart.
  - Expect done=1, cpu_run=1, pc_init=0; the core then executes with Reg[1]=120.
- Send the same frame with the CSUM byte off by one.
  - Expect 3 writes, then err=1, cpu_run=0, done=0, in_ready=0.
  - Further in_valid bytes are ignored until rst.
- Send addr 0x0078 with CNT 0, then CSUM.
  - Expect no mem_we, done=1, cpu_run=1, pc_init=120.
- Send addr 1020 with CNT 5 (ADDR_W=10).
  - Expect err=1 in the cycle after CNT_LO and no mem_we.
  - The same test with addr 0x0400 also gives err.
  - Addr 1019 with CNT 5 is accepted; its last write is at 1023.
- Send a 2-word frame with in_valid toggling randomly.
  - Expect words assembled MSB-first and correct addresses, with no counting during gaps.
- Assert rst after 1 word and 2 bytes of the second word.
  - Expect all reset values the next cycle.
  - A fresh frame then loads correctly, with no stale partial word written.
